// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory responder with wait states and RV32 lane steering
//
// Serves one dmem request at a time from an internal word RAM. A response
// (resp_valid pulse) follows each accepted request after LATENCY cycles.
// Stores are written on the accept edge with byte enables derived from the
// access width and address; loads are lane-steered and sign/zero extended.
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-high reset
//   req_valid        in   request present
//   req_ready        out  high while idle; a request is accepted on valid & ready
//   req_addr         in   [31:0] byte address
//   req_write_enable in   1 = store, 0 = load
//   req_write_data   in   [31:0] store data, LSB-aligned
//   req_data_width   in   [2:0] funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   resp_valid       out  one-cycle response pulse
//   resp_data        out  [31:0] extended load data; 0 for stores and faults
//   resp_err         out  access fault (misaligned, out of range, illegal width)
module dmem_responder #(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    LATENCY     = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_write_enable,
   input  logic [31:0] req_write_data,
   input  logic [2:0]  req_data_width,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err
);

   localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  WAIT_LOAD  = 4'(LATENCY - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [31:0] mem [DEPTH_WORDS];

   logic [1:0]    state;
   logic [3:0]    count;
   logic [AW-1:0] cap_index;
   logic [1:0]    cap_lane;
   logic [2:0]    cap_width;
   logic          cap_we;
   logic          cap_err;

   logic          accept;
   logic          misaligned;
   logic          out_of_range;
   logic          bad_width;
   logic          req_err;
   logic [3:0]    byte_en;
   logic [31:0]   lane_data;
   logic [AW-1:0] req_index;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic [31:0]   load_value;

   assign req_ready = (state == S_IDLE);
   assign accept    = req_valid && req_ready;
   assign req_index = req_addr[AW+1:2];

   // Request checks and store lane steering, evaluated on the live request.
   always_comb begin
      bad_width    = (req_data_width == 3'b011) || (req_data_width[2] && req_data_width[1]);
      out_of_range = ({1'b0, req_addr} >= BYTE_LIMIT);
      misaligned   = 1'b0;
      byte_en      = 4'b0000;
      lane_data    = req_write_data;
      case (req_data_width[1:0])
         2'b00: begin
            byte_en   = 4'b0001 << req_addr[1:0];
            lane_data = {4{req_write_data[7:0]}};
         end
         2'b01: begin
            misaligned = req_addr[0];
            byte_en    = req_addr[1] ? 4'b1100 : 4'b0011;
            lane_data  = {2{req_write_data[15:0]}};
         end
         2'b10: begin
            misaligned = (req_addr[1:0] != 2'b00);
            byte_en    = 4'b1111;
         end
         default: begin
            byte_en = 4'b0000;
         end
      endcase
      req_err = bad_width || misaligned || out_of_range;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         count     <= 4'd0;
         cap_index <= '0;
         cap_lane  <= 2'b00;
         cap_width <= 3'b000;
         cap_we    <= 1'b0;
         cap_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cap_index <= req_index;
                  cap_lane  <= req_addr[1:0];
                  cap_width <= req_data_width;
                  cap_we    <= req_write_enable;
                  cap_err   <= req_err;
                  if (LATENCY <= 1) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     count <= WAIT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               // The decrement that brings the counter to zero is the move to RESP.
               if (count <= 4'd1) begin
                  state <= S_RESP;
                  count <= 4'd0;
               end else begin
                  count <= count - 4'd1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Stores commit on the accept edge, so a later reset cannot undo them.
   always_ff @(posedge clk) begin
      if (accept && req_write_enable && !req_err) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[req_index][8*i +: 8] <= lane_data[8*i +: 8];
            end
         end
      end
   end

   // No request can be accepted while in RESP, so reading the array during
   // that cycle sees every earlier store.
   always_comb begin
      rd_word  = mem[cap_index];
      rd_shift = rd_word >> {cap_lane, 3'b000};
      case (cap_width[1:0])
         2'b00:   load_value = {{24{~cap_width[2] & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   load_value = {{16{~cap_width[2] & rd_shift[15]}}, rd_shift[15:0]};
         default: load_value = rd_shift;
      endcase
   end

   assign resp_valid = (state == S_RESP);
   assign resp_err   = (state == S_RESP) && cap_err;
   assign resp_data  = ((state == S_RESP) && !cap_err && !cap_we) ? load_value : 32'd0;

endmodule
